cram_loader: RTL and testbench

Sequencer directly upstream of the CPU data RAM (`cram`). It accepts a byte stream over a valid/ready handshake and packs byte pairs into `p_data_width` words. It writes those words to consecutive RAM addresses starting at a programmed base. While idle it passes the CPU's RAM port through unchanged; while loading it owns the RAM port and stalls the CPU.

---
 rtl/cram_loader.sv | 172 +++++++++++++++++
 tb/tb_cram_loader.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cram_loader.sv
// Byte-stream loader for the CPU data RAM: packs byte pairs into words and writes them from a base address.
// Optional read-back checksum pass is compiled in with CRAM_LOADER_VERIFY_EN.
module cram_loader #(
  parameter int p_data_width    = 16,
  parameter int p_address_width = 10
) (
  input  logic                       i_w_clk,
  input  logic                       i_w_rst_n,
  input  logic                       i_w_start,
  input  logic [p_address_width-1:0] i_w_base,
  input  logic [p_address_width-1:0] i_w_len,
  input  logic [7:0]                 i_w_byte,
  input  logic                       i_w_byte_valid,
  output logic                       o_w_byte_ready,
  output logic                       o_r_busy,
  output logic                       o_r_done,
  output logic                       o_w_cpu_stall,
  input  logic [p_address_width-1:0] i_w_cpu_address,
  input  logic [p_data_width-1:0]    i_w_cpu_data,
  input  logic                       i_w_cpu_we,
  input  logic                       i_w_cpu_oe,
  output logic [p_address_width-1:0] o_w_mem_address,
  output logic [p_data_width-1:0]    o_w_mem_data,
  output logic                       o_w_mem_we,
  output logic                       o_w_mem_oe,
  input  logic [p_data_width-1:0]    i_w_mem_rdata
`ifdef CRAM_LOADER_VERIFY_EN
  ,
  input  logic [15:0]                i_w_expected_sum,
  output logic                       o_r_sum_ok
`endif
);

  localparam int AW = p_address_width;
  localparam int DW = p_data_width;

`ifdef CRAM_LOADER_VERIFY_EN
  typedef enum logic [2:0] {
    S_IDLE, S_LO, S_HI, S_WRITE, S_DONE, S_VFY_ADDR, S_VFY_DATA
  } state_e;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_LO, S_HI, S_WRITE, S_DONE
  } state_e;
`endif

  state_e        state_q;
  logic [AW-1:0] addr_q;
  logic [AW-1:0] rem_q;
  logic [DW-1:0] data_q;
  logic          hs;

`ifdef CRAM_LOADER_VERIFY_EN
  logic [AW-1:0] base_q;
  logic [AW-1:0] len_q;
  logic [15:0]   sum_q;
  logic          sum_ok_q;
  assign o_r_sum_ok = sum_ok_q;
`else
  logic unused_rdata;
  assign unused_rdata = ^i_w_mem_rdata;
`endif

  // LO with nothing left only happens right after a zero-length start; no byte is taken then.
  assign o_w_byte_ready = (state_q == S_HI) || ((state_q == S_LO) && (rem_q != '0));
  assign hs             = o_w_byte_ready & i_w_byte_valid;
  assign o_r_busy       = (state_q != S_IDLE);
  assign o_w_cpu_stall  = o_r_busy;
  assign o_r_done       = (state_q == S_DONE);

  always_ff @(posedge i_w_clk or negedge i_w_rst_n) begin
    if (!i_w_rst_n) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      rem_q    <= '0;
      data_q   <= '0;
`ifdef CRAM_LOADER_VERIFY_EN
      base_q   <= '0;
      len_q    <= '0;
      sum_q    <= '0;
      sum_ok_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_w_start) begin
            addr_q  <= i_w_base;
            rem_q   <= i_w_len;
            state_q <= S_LO;
`ifdef CRAM_LOADER_VERIFY_EN
            base_q   <= i_w_base;
            len_q    <= i_w_len;
            sum_ok_q <= 1'b0;
`endif
          end
        end
        S_LO: begin
          if (rem_q == '0) begin
            state_q <= S_DONE;
`ifdef CRAM_LOADER_VERIFY_EN
            sum_ok_q <= (i_w_expected_sum == 16'h0000);
`endif
          end else if (hs) begin
            data_q[7:0] <= i_w_byte;
            state_q     <= S_HI;
          end
        end
        S_HI: begin
          if (hs) begin
            data_q[DW-1:8] <= i_w_byte;
            state_q        <= S_WRITE;
          end
        end
        S_WRITE: begin
          addr_q <= addr_q + 1'b1;
          rem_q  <= rem_q - 1'b1;
          if (rem_q == AW'(1)) begin
`ifdef CRAM_LOADER_VERIFY_EN
            // Rewind to the start of the block for the read-back pass.
            addr_q  <= base_q;
            rem_q   <= len_q;
            sum_q   <= '0;
            state_q <= S_VFY_ADDR;
`else
            state_q <= S_DONE;
`endif
          end else begin
            state_q <= S_LO;
          end
        end
`ifdef CRAM_LOADER_VERIFY_EN
        S_VFY_ADDR: state_q <= S_VFY_DATA;
        S_VFY_DATA: begin
          sum_q  <= sum_q + i_w_mem_rdata;
          addr_q <= addr_q + 1'b1;
          rem_q  <= rem_q - 1'b1;
          if (rem_q == AW'(1)) begin
            sum_ok_q <= ((sum_q + i_w_mem_rdata) == i_w_expected_sum);
            state_q  <= S_DONE;
          end else begin
            state_q <= S_VFY_ADDR;
          end
        end
`endif
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // RAM port: CPU passthrough only while idle, loader-owned otherwise.
  always_comb begin
    o_w_mem_address = addr_q;
    o_w_mem_data    = data_q;
    o_w_mem_we      = 1'b0;
    o_w_mem_oe      = 1'b0;
    case (state_q)
      S_IDLE: begin
        o_w_mem_address = i_w_cpu_address;
        o_w_mem_data    = i_w_cpu_data;
        o_w_mem_we      = i_w_cpu_we;
        o_w_mem_oe      = i_w_cpu_oe;
      end
      S_WRITE: o_w_mem_we = 1'b1;
`ifdef CRAM_LOADER_VERIFY_EN
      S_VFY_ADDR: o_w_mem_oe = 1'b1;
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cram_loader.sv
// Self-checking bench for cram_loader: behavioural RAM, random byte streams, array-based expected memory image.
module tb_cram_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [9:0]  base_i;
  logic [9:0]  len_i;
  logic [7:0]  byte_i;
  logic        vld;
  logic        ready;
  logic        busy;
  logic        done;
  logic        stall;
  logic [9:0]  cpu_addr;
  logic [15:0] cpu_data;
  logic        cpu_we;
  logic        cpu_oe;
  logic [9:0]  mem_addr;
  logic [15:0] mem_data;
  logic        mem_we;
  logic        mem_oe;
  logic [15:0] mem_rdata;
  logic [15:0] exp_sum_i;
  logic        sum_ok;

  int checks = 0;
  int errors = 0;

  logic [15:0] ram     [0:1023];
  logic [15:0] ref_mem [0:1023];
  logic        ram_clear;
  int          wr_cnt;
  logic [7:0]  bq[$];

  cram_loader #(.p_data_width(16), .p_address_width(10)) dut (
    .i_w_clk         (clk),
    .i_w_rst_n       (rst_n),
    .i_w_start       (start),
    .i_w_base        (base_i),
    .i_w_len         (len_i),
    .i_w_byte        (byte_i),
    .i_w_byte_valid  (vld),
    .o_w_byte_ready  (ready),
    .o_r_busy        (busy),
    .o_r_done        (done),
    .o_w_cpu_stall   (stall),
    .i_w_cpu_address (cpu_addr),
    .i_w_cpu_data    (cpu_data),
    .i_w_cpu_we      (cpu_we),
    .i_w_cpu_oe      (cpu_oe),
    .o_w_mem_address (mem_addr),
    .o_w_mem_data    (mem_data),
    .o_w_mem_we      (mem_we),
    .o_w_mem_oe      (mem_oe),
    .i_w_mem_rdata   (mem_rdata)
`ifdef CRAM_LOADER_VERIFY_EN
    ,
    .i_w_expected_sum(exp_sum_i),
    .o_r_sum_ok      (sum_ok)
`endif
  );

`ifndef CRAM_LOADER_VERIFY_EN
  assign sum_ok = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cram model: synchronous write, read data one cycle after an oe=1/we=0 request, else 0.
  always @(posedge clk) begin
    if (ram_clear) begin
      for (int i = 0; i < 1024; i++) ram[i] <= 16'h0000;
      wr_cnt    <= 0;
      mem_rdata <= 16'h0000;
    end else begin
      if (mem_we) begin
        ram[mem_addr] <= mem_data;
        wr_cnt        <= wr_cnt + 1;
      end
      mem_rdata <= (mem_oe && !mem_we) ? ram[mem_addr] : 16'h0000;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_ram(input string tag);
    int bad = 0;
    int first = -1;
    for (int i = 0; i < 1024; i++)
      if (ram[i] !== ref_mem[i]) begin
        bad++;
        if (first < 0) first = i;
      end
    checks++;
    assert (bad == 0) else begin
      errors++;
      $error("FAIL %s: %0d words differ, first at 0x%0h got 0x%0h expected 0x%0h",
             tag, bad, first, ram[first], ref_mem[first]);
    end
  endtask

  // mode 0: continuous valid, 1: random valid, 2: alternating valid plus a stray start pulse.
  task automatic run_load(input string tag, input logic [9:0] base, input int n, input int mode,
                          input bit rnd_bytes, input bit fix_exp, input logic [15:0] exp_val);
    int          idx;
    int          done_cyc;
    int          wr0;
    int          exp_done;
    logic        hs;
    logic [15:0] wsum;
    logic [9:0]  a;
    if (rnd_bytes) begin
      bq = {};
      for (int k = 0; k < 2 * n; k++) bq.push_back(8'($urandom));
    end
    wsum = 16'h0000;
    for (int k = 0; k < n; k++) wsum = wsum + {bq[2*k+1], bq[2*k]};
    exp_sum_i = fix_exp ? exp_val : (($urandom % 2) ? wsum : 16'($urandom));
    wr0    = wr_cnt;
    base_i = base;
    len_i  = 10'(n);
    start  = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    cpu_we   = 1'b1;
    cpu_addr = 10'h2AA;
    cpu_data = 16'hDEAD;
    idx      = 0;
    done_cyc = -1;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      if (busy !== 1'b1 || stall !== 1'b1) chk({tag, " busy/stall during load"}, {busy, stall}, 2'b11);
      if (done) begin
        done_cyc = cyc;
        break;
      end
      case (mode)
        0:       vld = 1'b1;
        1:       vld = 1'($urandom % 2);
        default: vld = 1'(cyc % 2);
      endcase
      if (idx >= 2 * n) vld = 1'b0;
      byte_i = (idx < 2 * n) ? bq[idx] : 8'h00;
      if (mode == 2 && cyc == 4) begin
        start  = 1'b1;
        base_i = 10'h003;
        len_i  = 10'd5;
      end else begin
        start = 1'b0;
      end
      hs = ready && vld;
      @(posedge clk); #1;
      if (hs) idx++;
    end
    start  = 1'b0;
    vld    = 1'b0;
    cpu_we = 1'b0;
    checks++;
    assert (done_cyc > 0) else begin
      errors++;
      $error("FAIL %s done timeout: got none expected pulse", tag);
    end
    if (mode == 0) begin
      exp_done = (n == 0) ? 2 : 3 * n + 1;
`ifdef CRAM_LOADER_VERIFY_EN
      if (n > 0) exp_done = exp_done + 2 * n;
`endif
      chk({tag, " done cycle"}, 32'(done_cyc), 32'(exp_done));
    end
    chk({tag, " bytes consumed"}, 32'(idx), 32'(2 * n));
    @(posedge clk); #1;
    chk({tag, " idle after done"}, {busy, stall, done}, 3'b000);
    chk({tag, " write count"}, 32'(wr_cnt - wr0), 32'(n));
    for (int k = 0; k < n; k++) begin
      a = base + 10'(k);
      ref_mem[a] = {bq[2*k+1], bq[2*k]};
    end
    chk_ram({tag, " ram image"});
`ifdef CRAM_LOADER_VERIFY_EN
    chk({tag, " sum_ok"}, 32'(sum_ok), 32'(wsum == exp_sum_i));
`endif
  endtask

  initial begin
    logic [7:0] rb [0:3];
    logic       hs;
    int         idx;
    rst_n = 1'b0; start = 1'b0; base_i = '0; len_i = '0; byte_i = '0; vld = 1'b0;
    cpu_addr = '0; cpu_data = '0; cpu_we = 1'b0; cpu_oe = 1'b0; exp_sum_i = '0;
    ram_clear = 1'b1;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    chk("reset outputs", {ready, busy, done, stall, mem_we, mem_oe}, 6'b0);
    ram_clear = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // CPU passthrough while idle
    cpu_addr = 10'h010; cpu_data = 16'hBEEF; cpu_we = 1'b1;
    #1;
    chk("idle passthrough addr", 32'(mem_addr), 32'h010);
    chk("idle passthrough data", 32'(mem_data), 32'hBEEF);
    chk("idle passthrough we", 32'(mem_we), 32'h1);
    @(posedge clk); #1;
    cpu_we = 1'b0;
    ref_mem[10'h010] = 16'hBEEF;
    chk("cpu write reached ram", 32'(ram[10'h010]), 32'hBEEF);

    bq = {8'h34, 8'h12, 8'hCD, 8'hAB};
    run_load("base5", 10'h005, 2, 0, 1'b0, 1'b0, 16'h0);
    chk("ram[5]", 32'(ram[5]), 32'h1234);
    chk("ram[6]", 32'(ram[6]), 32'hABCD);

    run_load("wrap", 10'h3FF, 2, 0, 1'b1, 1'b0, 16'h0);
    run_load("len0", 10'h123, 0, 0, 1'b1, 1'b0, 16'h0);
    run_load("toggle+start", 10'h080, 4, 2, 1'b1, 1'b0, 16'h0);
    for (int t = 0; t < 6; t++)
      run_load("random", 10'($urandom), 1 + int'($urandom % 8), (t % 2 == 0) ? 1 : 0, 1'b1, 1'b0, 16'h0);

    // Reset while in HI of the second word; first word must survive.
    for (int k = 0; k < 4; k++) rb[k] = 8'($urandom);
    base_i = 10'h040; len_i = 10'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    idx = 0;
    for (int cyc = 1; cyc < 5; cyc++) begin
      vld    = 1'b1;
      byte_i = rb[idx];
      hs     = ready && vld;
      @(posedge clk); #1;
      if (hs) idx++;
    end
    chk("pre-reset in HI", {ready, busy}, 2'b11);
    rst_n = 1'b0;
    vld   = 1'b0;
    #1;
    chk("mid-load reset outputs", {ready, busy, done, stall, mem_we, mem_oe}, 6'b0);
    @(negedge clk);
    rst_n = 1'b1;
    ref_mem[10'h040] = {rb[1], rb[0]};
    chk("ram kept first word", 32'(ram[10'h040]), 32'({rb[1], rb[0]}));
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0) chk("no done after reset", {done, busy}, 2'b00);
    end
    chk_ram("after reset ram image");

`ifdef CRAM_LOADER_VERIFY_EN
    bq = {8'h01, 8'h00, 8'hFF, 8'hFF};
    run_load("vfy ok", 10'h100, 2, 0, 1'b0, 1'b1, 16'h0000);
    chk("vfy sum_ok=1", 32'(sum_ok), 32'h1);
    run_load("vfy bad", 10'h100, 2, 0, 1'b0, 1'b1, 16'h0001);
    chk("vfy sum_ok=0", 32'(sum_ok), 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
